mux_packer: RTL and testbench

//  Return path of the decryption datapath: collects 8-bit bytes from one of three

---
 rtl/dec_pkg.sv | 11 +
 rtl/byte_pack_reg.sv | 43 ++++
 rtl/mux_packer.sv | 60 ++++++
 tb/tb_mux_packer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// dec_pkg: shared widths, select encodings and packer FSM states for the decryption datapath
package dec_pkg;
  localparam int MST_DWIDTH = 32;
  localparam int SYS_DWIDTH = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] SEL_CH0 = 2'd0;
  localparam logic [1:0] SEL_CH1 = 2'd1;
  localparam logic [1:0] SEL_CH2 = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;
  typedef enum logic {IDLE, FILL} state_t;
endpackage

// File: rtl/byte_pack_reg.sv
// byte_pack_reg: MSB-first byte position register with byte count
//  clk_sys/rst_n  clock, async active-low reset
//  din            byte to store at the current position
//  load           store din and advance the count
//  clear          discard the partial word; a same-cycle load becomes byte 0
//  word           packed word including this cycle's byte (complete when full)
//  full           this cycle's load completes a word
module byte_pack_reg
  import dec_pkg::*;
#(
  parameter int MST_DWIDTH = dec_pkg::MST_DWIDTH,
  parameter int SYS_DWIDTH = dec_pkg::SYS_DWIDTH
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [SYS_DWIDTH-1:0] din,
  input  logic                  load,
  input  logic                  clear,
  output logic [MST_DWIDTH-1:0] word,
  output logic                  full
);
  localparam int N = MST_DWIDTH / SYS_DWIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  logic [MST_DWIDTH-1:0] shreg;
  logic [CW-1:0] count, pos;
  // clear restarts at position 0 so a byte arriving with the clear starts the new word
  assign pos = clear ? '0 : count;
  assign full = load && pos == LAST;
  always_comb begin
    word = clear ? '0 : shreg;
    for (int i = 0; i < N; i++)
      if (load && pos == i[CW-1:0]) word[MST_DWIDTH-1-SYS_DWIDTH*i -: SYS_DWIDTH] = din;
  end
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
    end else begin
      shreg <= word;
      count <= load ? pos + 1'b1 : pos;
    end
endmodule

// File: rtl/mux_packer.sv
// mux_packer: selects one of three byte channels and packs bytes MSB-first into words
//  clk_sys/rst_n          clock, async active-low reset
//  select                 0/1/2 = channel, 3 = none
//  dataN_i/validN_i       channel N byte and qualifier
//  data_o                 last completed word (held between pulses)
//  valid_o                one-cycle pulse per completed word
module mux_packer
  import dec_pkg::*;
#(
  parameter int MST_DWIDTH = dec_pkg::MST_DWIDTH,
  parameter int SYS_DWIDTH = dec_pkg::SYS_DWIDTH
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [1:0]            select,
  input  logic [SYS_DWIDTH-1:0] data0_i,
  input  logic                  valid0_i,
  input  logic [SYS_DWIDTH-1:0] data1_i,
  input  logic                  valid1_i,
  input  logic [SYS_DWIDTH-1:0] data2_i,
  input  logic                  valid2_i,
  output logic [MST_DWIDTH-1:0] data_o,
  output logic                  valid_o
);
  logic [1:0] sel_q;
  logic [SYS_DWIDTH-1:0] din;
  logic [MST_DWIDTH-1:0] word;
  logic load, clear, full;
  state_t state, state_nxt;
  assign din = select == SEL_CH0 ? data0_i : select == SEL_CH1 ? data1_i : data2_i;
  assign load = select == SEL_CH0 ? valid0_i : select == SEL_CH1 ? valid1_i :
                select == SEL_CH2 && valid2_i;
  // any select change, including to or from SEL_NONE, drops the partial word
  assign clear = select != sel_q;
  byte_pack_reg #(.MST_DWIDTH(MST_DWIDTH), .SYS_DWIDTH(SYS_DWIDTH)) u_pack (
    .clk_sys(clk_sys),
    .rst_n  (rst_n),
    .din    (din),
    .load   (load),
    .clear  (clear),
    .word   (word),
    .full   (full)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = load && !full ? FILL : clear || full ? IDLE : state;
  end
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= SEL_NONE;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_q   <= select;
      valid_o <= full;
      if (full) data_o <= word;
    end
endmodule

// File: tb/tb_mux_packer.sv
// tb_mux_packer: directed self-checking bench for mux_packer
module tb_mux_packer;
  logic clk_sys = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] select = 2'd3;
  logic [7:0] data0_i = '0, data1_i = '0, data2_i = '0;
  logic valid0_i = 1'b0, valid1_i = 1'b0, valid2_i = 1'b0;
  logic [31:0] data_o;
  logic valid_o;
  int errors = 0;
  int checks = 0;

  mux_packer dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .select  (select),
    .data0_i (data0_i),
    .valid0_i(valid0_i),
    .data1_i (data1_i),
    .valid1_i(valid1_i),
    .data2_i (data2_i),
    .valid2_i(valid2_i),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  always #5 clk_sys = ~clk_sys;

  // the selected channel carries d, the others ~d so a wrong mux path is visible
  task automatic cyc(input logic [1:0] s, input logic [2:0] v, input logic [7:0] d);
    select = s;
    {valid2_i, valid1_i, valid0_i} = v;
    data0_i = s == 2'd0 ? d : ~d;
    data1_i = s == 2'd1 ? d : ~d;
    data2_i = s == 2'd2 ? d : ~d;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want %h", data_o, 32'h0); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] b[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) begin
      cyc(2'd0, 3'b001, b[i]);
      checks++;
      if (valid_o !== (i == 3)) begin errors++; $display("FAIL basic_valid[%0d]: got %b want %b", i, valid_o, i == 3); end
    end
    checks++;
    if (data_o !== 32'hAABBCCDD) begin errors++; $display("FAIL basic_data: got %h want AABBCCDD", data_o); end
    cyc(2'd0, 3'b000, 8'h00);
    checks++;
    if (valid_o !== 1'b0 || data_o !== 32'hAABBCCDD) begin
      errors++; $display("FAIL basic_hold: got %b/%h want 0/AABBCCDD", valid_o, data_o);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b[4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    cyc(2'd0, 3'b001, 8'h55);
    cyc(2'd0, 3'b001, 8'h66);
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_o !== 32'h0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_async: got %b/%h want 0/00000000", valid_o, data_o);
    end
    @(posedge clk_sys);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(2'd0, 3'b001, b[i]);
      checks++;
      if (valid_o !== (i == 3)) begin errors++; $display("FAIL mid_reset_valid[%0d]: got %b want %b", i, valid_o, i == 3); end
      if (i < 3) begin
        checks++;
        if (data_o !== 32'h0) begin errors++; $display("FAIL mid_reset_data[%0d]: got %h want 0", i, data_o); end
      end
    end
    checks++;
    if (data_o !== 32'h5A6B7C8D) begin errors++; $display("FAIL mid_reset_word: got %h want 5A6B7C8D", data_o); end
  endtask

  task automatic test_gap;
    cyc(2'd1, 3'b010, 8'h11);
    cyc(2'd1, 3'b010, 8'h22);
    for (int i = 0; i < 5; i++) begin
      cyc(2'd1, i % 2 ? 3'b101 : 3'b001, 8'hF0 + 8'(i));
      checks++;
      if (valid_o !== 1'b0 || data_o !== 32'h5A6B7C8D) begin
        errors++; $display("FAIL gap_hold[%0d]: got %b/%h want 0/5A6B7C8D", i, valid_o, data_o);
      end
    end
    cyc(2'd1, 3'b111, 8'h33);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL gap_early: got %b want 0", valid_o); end
    cyc(2'd1, 3'b010, 8'h44);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'h11223344) begin
      errors++; $display("FAIL gap_word: got %b/%h want 1/11223344", valid_o, data_o);
    end
    cyc(2'd1, 3'b000, 8'h00);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL gap_single_pulse: got %b want 0", valid_o); end
  endtask

  task automatic test_switch;
    cyc(2'd2, 3'b100, 8'h01);
    cyc(2'd2, 3'b100, 8'h02);
    cyc(2'd0, 3'b101, 8'h0A);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL switch_0A: got %b want 0", valid_o); end
    cyc(2'd0, 3'b001, 8'h0B);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL switch_0B: got %b want 0", valid_o); end
    cyc(2'd0, 3'b001, 8'h0C);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL switch_0C: got %b want 0", valid_o); end
    cyc(2'd0, 3'b001, 8'h0D);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'h0A0B0C0D) begin
      errors++; $display("FAIL switch_word: got %b/%h want 1/0A0B0C0D", valid_o, data_o);
    end
    cyc(2'd0, 3'b000, 8'h00);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      cyc(2'd0, 3'b001, 8'(i));
      exp = i < 3 ? 32'h0A0B0C0D : i < 7 ? 32'h00010203 : 32'h04050607;
      checks++;
      if (valid_o !== (i % 4 == 3) || data_o !== exp) begin
        errors++; $display("FAIL b2b[%0d]: got %b/%h want %b/%h", i, valid_o, data_o, i % 4 == 3, exp);
      end
    end
  endtask

  task automatic test_none;
    logic [7:0] b[4] = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    for (int i = 0; i < 8; i++) begin
      cyc(2'd3, 3'b111, 8'h90 + 8'(i));
      checks++;
      if (valid_o !== 1'b0 || data_o !== 32'h04050607) begin
        errors++; $display("FAIL none[%0d]: got %b/%h want 0/04050607", i, valid_o, data_o);
      end
    end
    for (int i = 0; i < 4; i++) cyc(2'd0, 3'b001, b[i]);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 32'hE1E2E3E4) begin
      errors++; $display("FAIL none_resume: got %b/%h want 1/E1E2E3E4", valid_o, data_o);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_reset_mid;
    test_gap;
    test_switch;
    test_back_to_back;
    test_none;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
